banked_regfile: RTL and testbench



---
 rtl/banked_regfile.sv | 124 ++++++++++++
 tb/tb_banked_regfile.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/banked_regfile.sv
// Physical ARM register file: 31 banked GPR entries, dedicated PC with auto-increment,
// PC+8 read value and PC-write pulse. Optional same-cycle write forwarding: REGFILE_WRITE_BYPASS_EN.
module banked_regfile #(
  parameter int                 DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ra_idx,
  input  logic [4:0]        rb_idx,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              we,
  input  logic [4:0]        wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pc_en,
  output logic [DATA_W-1:0] pc_out,
  output logic              pc_written
);

  // Banked physical indices 16..30 as produced by the mode/address mapper.
  localparam logic [4:0] R8_FIQ   = 5'd16;
  localparam logic [4:0] R9_FIQ   = 5'd17;
  localparam logic [4:0] R10_FIQ  = 5'd18;
  localparam logic [4:0] R11_FIQ  = 5'd19;
  localparam logic [4:0] R12_FIQ  = 5'd20;
  localparam logic [4:0] R13_FIQ  = 5'd21;
  localparam logic [4:0] R14_FIQ  = 5'd22;
  localparam logic [4:0] R13_SVC  = 5'd23;
  localparam logic [4:0] R14_SVC  = 5'd24;
  localparam logic [4:0] R13_ABT  = 5'd25;
  localparam logic [4:0] R14_ABT  = 5'd26;
  localparam logic [4:0] R13_IRQ  = 5'd27;
  localparam logic [4:0] R14_IRQ  = 5'd28;
  localparam logic [4:0] R13_UND  = 5'd29;
  localparam logic [4:0] R14_UND  = 5'd30;
  localparam logic [4:0] PC_IDX   = 5'd15;
  localparam logic [4:0] NULL_IDX = 5'd31;
  localparam int         N_ENTRY  = 31;

  localparam logic [DATA_W-1:0] PC_INC    = DATA_W'(PC_STEP);
  localparam logic [DATA_W-1:0] PC_OFFSET = DATA_W'(8);

  // Slot 15 of the array is never written; the PC lives in its own register.
  logic [DATA_W-1:0] r_regs [0:N_ENTRY-1];
  logic [DATA_W-1:0] r_pc;
  logic              r_pc_written;

  logic              w_wr_gpr;
  logic              w_wr_pc;
  logic [DATA_W-1:0] w_pc_plus8;
  logic [DATA_W-1:0] w_pc_wr_val;
  logic [DATA_W-1:0] w_ra_data;
  logic [DATA_W-1:0] w_rb_data;

  assign w_wr_gpr    = we && (wr_idx != PC_IDX) && (wr_idx != NULL_IDX);
  assign w_wr_pc     = we && (wr_idx == PC_IDX);
  assign w_pc_plus8  = r_pc + PC_OFFSET;
  assign w_pc_wr_val = {wr_data[DATA_W-1:2], 2'b00};

  // NOTE: every state element is updated with <= so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is reset explicitly because banked entries must read 0 after reset;
      // a pure RAM without this requirement would normally be left unreset.
      for (int i = 0; i < N_ENTRY; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_gpr) begin
      r_regs[wr_idx] <= wr_data;
    end
  end

  // A PC write outranks the auto-increment in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_pc_written <= 1'b0;
    end else begin
      if (w_wr_pc) begin
        r_pc <= w_pc_wr_val;
      end else if (pc_en) begin
        r_pc <= r_pc + PC_INC;
      end
      r_pc_written <= w_wr_pc;
    end
  end

  // NOTE: defaults come first in every always_comb so no path leaves an output unassigned (no latch).
  always_comb begin
    w_ra_data = '0;
    if (ra_idx == PC_IDX) begin
      w_ra_data = w_pc_plus8;
    end else if (ra_idx != NULL_IDX) begin
      w_ra_data = r_regs[ra_idx];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (w_wr_gpr && (ra_idx == wr_idx)) begin
      w_ra_data = wr_data;
    end
`endif
  end

  always_comb begin
    w_rb_data = '0;
    if (rb_idx == PC_IDX) begin
      w_rb_data = w_pc_plus8;
    end else if (rb_idx != NULL_IDX) begin
      w_rb_data = r_regs[rb_idx];
    end
`ifdef REGFILE_WRITE_BYPASS_EN
    if (w_wr_gpr && (rb_idx == wr_idx)) begin
      w_rb_data = wr_data;
    end
`endif
  end

  assign ra_data    = w_ra_data;
  assign rb_data    = w_rb_data;
  assign pc_out     = r_pc;
  assign pc_written = r_pc_written;

endmodule

// File: tb/tb_banked_regfile.sv
// Scoreboard bench for banked_regfile: directed vectors push expected outputs,
// a negedge monitor pops and compares them. Honors REGFILE_WRITE_BYPASS_EN.
module tb_banked_regfile;

  localparam int DW = 32;

  localparam logic [4:0] R13_SVC = 5'd23;

  logic          clk;
  logic          rst;
  logic [4:0]    ra_idx;
  logic [4:0]    rb_idx;
  logic [DW-1:0] ra_data;
  logic [DW-1:0] rb_data;
  logic          we;
  logic [4:0]    wr_idx;
  logic [DW-1:0] wr_data;
  logic          pc_en;
  logic [DW-1:0] pc_out;
  logic          pc_written;

  banked_regfile #(.DATA_W(DW), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ra_idx     (ra_idx),
    .rb_idx     (rb_idx),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .we         (we),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .pc_en      (pc_en),
    .pc_out     (pc_out),
    .pc_written (pc_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic [DW-1:0] ea;
    logic [DW-1:0] eb;
    logic [DW-1:0] epc;
    logic          epw;
  } exp_t;

  exp_t q[$];
  logic sample_vld;
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: outputs are sampled mid-cycle, i.e. before the edge commits the vector's write.
  always @(negedge clk) begin
    exp_t e;
    if (sample_vld) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_empty: got no expectation, required one");
      end else begin
        e = q.pop_front();
        check({e.name, ".ra"}, ra_data, e.ea);
        check({e.name, ".rb"}, rb_data, e.eb);
        check({e.name, ".pc"}, pc_out, e.epc);
        check({e.name, ".pw"}, {{(DW-1){1'b0}}, pc_written}, {{(DW-1){1'b0}}, e.epw});
      end
    end
  end

  task automatic apply(input string name, input logic [4:0] ra, input logic [4:0] rb,
                       input logic w, input logic [4:0] wi, input logic [DW-1:0] wd,
                       input logic pe, input logic rs,
                       input logic [DW-1:0] ea, input logic [DW-1:0] eb,
                       input logic [DW-1:0] epc, input logic epw);
    exp_t e;
    ra_idx  = ra;
    rb_idx  = rb;
    we      = w;
    wr_idx  = wi;
    wr_data = wd;
    pc_en   = pe;
    rst     = rs;
    e.name = name; e.ea = ea; e.eb = eb; e.epc = epc; e.epw = epw;
    q.push_back(e);
    sample_vld = 1'b1;
    @(posedge clk);
    #1;
    sample_vld = 1'b0;
    we = 1'b0; pc_en = 1'b0; rst = 1'b0;
  endtask

  logic [DW-1:0] bp_dead, bp_1000, bp_2000, bp_7;

  initial begin
    n_pass = 0; n_total = 0; sample_vld = 1'b0;
    ra_idx = '0; rb_idx = '0; we = 1'b0; wr_idx = '0; wr_data = '0; pc_en = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef REGFILE_WRITE_BYPASS_EN
    bp_dead = 32'hDEADBEEF; bp_1000 = 32'h1000; bp_2000 = 32'h2000; bp_7 = 32'd2;
`else
    bp_dead = 32'h0;        bp_1000 = 32'h0;    bp_2000 = 32'h0;    bp_7 = 32'd1;
`endif

    //     name        ra     rb     we  wi     wd            pe rs  exp_a         exp_b         exp_pc        pw
    apply("reset",     5'd0,  5'd15, 0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h8,        32'h0,        0);
    apply("wr3",       5'd3,  5'd4,  1, 5'd3,  32'hDEADBEEF, 0, 0, bp_dead,      32'h0,        32'h0,        0);
    apply("rd3",       5'd3,  5'd4,  0, 5'd0,  32'h0,        0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        0);
    apply("wr13",      5'd13, 5'd23, 1, 5'd13, 32'h1000,     0, 0, bp_1000,      32'h0,        32'h0,        0);
    apply("wr13svc",   5'd13, 5'd23, 1, R13_SVC, 32'h2000,   0, 0, 32'h1000,     bp_2000,      32'h0,        0);
    apply("bank",      5'd13, R13_SVC, 0, 5'd0, 32'h0,       0, 0, 32'h1000,     32'h2000,     32'h0,        0);
    for (int i = 16; i <= 22; i++) begin
      apply($sformatf("fiq%0d", i), 5'(i), 5'(i + 8), 0, 5'd0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    end
    apply("pcen0",     5'd15, 5'd31, 0, 5'd0,  32'h0,        1, 0, 32'h8,        32'h0,        32'h0,        0);
    apply("pcen1",     5'd15, 5'd31, 0, 5'd0,  32'h0,        1, 0, 32'hC,        32'h0,        32'h4,        0);
    apply("pcen2",     5'd15, 5'd31, 0, 5'd0,  32'h0,        1, 0, 32'h10,       32'h0,        32'h8,        0);
    apply("pc12",      5'd15, 5'd0,  0, 5'd0,  32'h0,        0, 0, 32'h14,       32'h0,        32'hC,        0);
    apply("wrpc",      5'd15, 5'd15, 1, 5'd15, 32'h103,      1, 0, 32'h14,       32'h14,       32'hC,        0);
    apply("pcw1",      5'd15, 5'd0,  0, 5'd0,  32'h0,        0, 0, 32'h108,      32'h0,        32'h100,      1);
    apply("pcw0",      5'd15, 5'd0,  0, 5'd0,  32'h0,        0, 0, 32'h108,      32'h0,        32'h100,      0);
    apply("b2b1",      5'd0,  5'd0,  1, 5'd15, 32'h200,      0, 0, 32'h0,        32'h0,        32'h100,      0);
    apply("b2b2",      5'd0,  5'd0,  1, 5'd15, 32'h300,      0, 0, 32'h0,        32'h0,        32'h200,      1);
    apply("b2b3",      5'd0,  5'd0,  0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0,        32'h300,      1);
    apply("b2b4",      5'd0,  5'd0,  0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0,        32'h300,      0);
    apply("wrffc",     5'd15, 5'd0,  1, 5'd15, 32'hFFFFFFFC, 0, 0, 32'h308,      32'h0,        32'h300,      0);
    apply("pcffc",     5'd15, 5'd0,  0, 5'd0,  32'h0,        1, 0, 32'h4,        32'h0,        32'hFFFFFFFC, 1);
    apply("wrap",      5'd15, 5'd0,  0, 5'd0,  32'h0,        0, 0, 32'h8,        32'h0,        32'h0,        0);
    apply("wr31",      5'd31, 5'd3,  1, 5'd31, 32'h55,       0, 0, 32'h0,        32'hDEADBEEF, 32'h0,        0);
    apply("rd31",      5'd31, 5'd3,  0, 5'd0,  32'h0,        0, 0, 32'h0,        32'hDEADBEEF, 32'h0,        0);
    apply("wr7old",    5'd0,  5'd0,  1, 5'd7,  32'd1,        0, 0, 32'h0,        32'h0,        32'h0,        0);
    apply("rdw7",      5'd7,  5'd7,  1, 5'd7,  32'd2,        0, 0, bp_7,         bp_7,         32'h0,        0);
    apply("rd7",       5'd7,  5'd13, 0, 5'd0,  32'h0,        0, 0, 32'd2,        32'h1000,     32'h0,        0);
    apply("rstwe",     5'd3,  5'd0,  1, 5'd9,  32'hABCD,     1, 1, 32'hDEADBEEF, 32'h0,        32'h0,        0);
    apply("postrst",   5'd9,  5'd3,  0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h0,        32'h0,        0);
    apply("postrst2",  5'd23, 5'd15, 0, 5'd0,  32'h0,        0, 0, 32'h0,        32'h8,        32'h0,        0);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expectations, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
